// File: rtl/mem_req_issuer.sv
// mem_req_issuer: buffers Rd/Wr commands, issues them one at a time to mem_system,
// holds each request until Done, returns the reply and tracks latency/perf counters.
// Optional feature macro: MEM_REQ_MAXLAT_EN (adds max_lat tracking and bad_addr capture).
module mem_req_issuer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned CNT_W    = 16,
    parameter int unsigned HIT_MAX  = 2,
    parameter int unsigned MISS_MAX = 20,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic             clk,
    input  logic             rst,
    // command intake
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_wr,
    input  logic             in_rd,
    input  logic [15:0]      in_addr,
    input  logic [15:0]      in_data,
    // mem_system interface
    output logic [15:0]      Addr,
    output logic [15:0]      DataIn,
    output logic             Rd,
    output logic             Wr,
    input  logic [15:0]      DataOut,
    input  logic             Done,
    input  logic             Stall,
    input  logic             CacheHit,
    // reply
    output logic             rsp_valid,
    output logic [15:0]      rsp_data,
    output logic             rsp_hit,
    output logic [7:0]       rsp_lat,
    // statistics and status
    output logic [CNT_W-1:0] n_req,
    output logic [CNT_W-1:0] n_reply,
    output logic [CNT_W-1:0] n_hit,
    output logic             err_perf,
    output logic             err_drop,
    output logic             err_cmd,
    output logic             idle,
    output logic [7:0]       max_lat,
    output logic [15:0]      bad_addr
);

    localparam int unsigned PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_FW = $clog2(DEPTH + 1);
    localparam int unsigned ENT_W  = 33;
    localparam int unsigned LAT_W  = 8;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_BUSY = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [ENT_W-1:0]    fifo_mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;
    logic [CNT_FW-1:0]   fifo_cnt;
    logic [CNT_FW-1:0]   cnt_nxt;
    logic [ENT_W-1:0]    head;
    logic [LAT_W-1:0]    lat;

    logic                accept_c;
    logic                push_c;
    logic                bad_cmd_c;
    logic                issue_c;
    logic                reply_c;
    logic                drop_c;
    logic                perf_bad_c;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Intake decode: only well-formed commands are stored; rd=wr=1 is flagged and dropped
    assign accept_c  = in_valid & in_ready;
    assign push_c    = accept_c & (in_rd ^ in_wr);
    assign bad_cmd_c = accept_c & in_rd & in_wr;
    assign head      = fifo_mem[rd_ptr];

    // Latency budget check evaluated on the Done cycle
    assign perf_bad_c = reply_c &
                        (CacheHit ? (lat > LAT_W'(HIT_MAX))
                                  : ((lat <= LAT_W'(HIT_MAX)) | (lat > LAT_W'(MISS_MAX))));

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if ((fifo_cnt != '0) && !Stall) state_nxt = S_BUSY;
            S_BUSY:  if (Done || (lat == LAT_W'(TIMEOUT))) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM control strobes for the datapath
    always_comb begin
        issue_c = 1'b0;
        reply_c = 1'b0;
        drop_c  = 1'b0;
        case (state)
            S_IDLE: issue_c = (fifo_cnt != '0) && !Stall;
            S_BUSY: begin
                reply_c = Done;
                drop_c  = !Done && (lat == LAT_W'(TIMEOUT));
            end
            default: ;
        endcase
    end

    // Occupancy after this cycle's push/pop
    always_comb begin
        cnt_nxt = fifo_cnt;
        if (push_c && !issue_c)      cnt_nxt = fifo_cnt + CNT_FW'(1);
        else if (!push_c && issue_c) cnt_nxt = fifo_cnt - CNT_FW'(1);
    end

    // FIFO storage write
    always_ff @(posedge clk) begin
        if (push_c) fifo_mem[wr_ptr] <= {in_wr, in_addr, in_data};
    end

    // FIFO pointers, occupancy and registered ready/idle status
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            in_ready <= 1'b1;
            idle     <= 1'b1;
        end else begin
            if (push_c)  wr_ptr <= wr_ptr + PTR_W'(1);
            if (issue_c) rd_ptr <= rd_ptr + PTR_W'(1);
            fifo_cnt <= cnt_nxt;
            in_ready <= (cnt_nxt != CNT_FW'(DEPTH));
            idle     <= (cnt_nxt == '0) && (state_nxt == S_IDLE);
        end
    end

    // Request outputs to mem_system and the latency counter
    always_ff @(posedge clk) begin
        if (rst) begin
            Addr   <= '0;
            DataIn <= '0;
            Rd     <= 1'b0;
            Wr     <= 1'b0;
            lat    <= '0;
        end else if (issue_c) begin
            Addr   <= head[31:16];
            DataIn <= head[15:0];
            Wr     <= head[32];
            Rd     <= ~head[32];
            lat    <= LAT_W'(1);
        end else if (reply_c || drop_c) begin
            Rd     <= 1'b0;
            Wr     <= 1'b0;
        end else if (state == S_BUSY) begin
            lat    <= (&lat) ? lat : lat + LAT_W'(1);
        end
    end

    // One-cycle reply pulse following Done
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_hit   <= 1'b0;
            rsp_lat   <= '0;
        end else begin
            rsp_valid <= reply_c;
            rsp_data  <= (reply_c && Rd) ? DataOut : 16'h0000;
            rsp_hit   <= reply_c & CacheHit;
            rsp_lat   <= reply_c ? lat : 8'h00;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk) begin
        if (rst) begin
            n_req   <= '0;
            n_reply <= '0;
            n_hit   <= '0;
        end else begin
            if (issue_c)             n_req   <= sat_inc(n_req);
            if (reply_c)             n_reply <= sat_inc(n_reply);
            if (reply_c && CacheHit) n_hit   <= sat_inc(n_hit);
        end
    end

    // Sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            err_perf <= 1'b0;
            err_drop <= 1'b0;
            err_cmd  <= 1'b0;
        end else begin
            if (perf_bad_c) err_perf <= 1'b1;
            if (drop_c)     err_drop <= 1'b1;
            if (bad_cmd_c)  err_cmd  <= 1'b1;
        end
    end

`ifdef MEM_REQ_MAXLAT_EN
    // Worst-case latency and the first address that broke the latency budget
    always_ff @(posedge clk) begin
        if (rst) begin
            max_lat  <= '0;
            bad_addr <= '0;
        end else begin
            if (reply_c && (lat > max_lat)) max_lat  <= lat;
            if (perf_bad_c && !err_perf)    bad_addr <= Addr;
        end
    end
`else
    assign max_lat  = 8'h00;
    assign bad_addr = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_req_issuer.sv
// Directed self-checking bench for mem_req_issuer; the bench plays mem_system and
// keeps a scoreboard of expected replies pushed when each command is offered.
module tb_mem_req_issuer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_wr;
    logic        in_rd;
    logic [15:0] in_addr;
    logic [15:0] in_data;
    logic [15:0] Addr;
    logic [15:0] DataIn;
    logic        Rd;
    logic        Wr;
    logic [15:0] DataOut;
    logic        Done;
    logic        Stall;
    logic        CacheHit;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_hit;
    logic [7:0]  rsp_lat;
    logic [15:0] n_req;
    logic [15:0] n_reply;
    logic [15:0] n_hit;
    logic        err_perf;
    logic        err_drop;
    logic        err_cmd;
    logic        idle;
    logic [7:0]  max_lat;
    logic [15:0] bad_addr;

    mem_req_issuer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_wr(in_wr), .in_rd(in_rd),
        .in_addr(in_addr), .in_data(in_data),
        .Addr(Addr), .DataIn(DataIn), .Rd(Rd), .Wr(Wr),
        .DataOut(DataOut), .Done(Done), .Stall(Stall), .CacheHit(CacheHit),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_hit(rsp_hit), .rsp_lat(rsp_lat),
        .n_req(n_req), .n_reply(n_reply), .n_hit(n_hit),
        .err_perf(err_perf), .err_drop(err_drop), .err_cmd(err_cmd), .idle(idle),
        .max_lat(max_lat), .bad_addr(bad_addr)
    );

    typedef struct packed {
        logic [15:0] data;
        logic        hit;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   waited;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Offer one command and hold it until accepted
    task automatic push_cmd(input logic rd, input logic wr, input logic [15:0] a,
                            input logic [15:0] d);
        int guard;
        guard    = 0;
        in_valid = 1'b1;
        in_rd    = rd;
        in_wr    = wr;
        in_addr  = a;
        in_data  = d;
        while (!in_ready && guard < 100) begin
            tick();
            guard++;
        end
        if (!in_ready) check("push_ready_timeout", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_rd    = 1'b0;
        in_wr    = 1'b0;
    endtask

    // Act as mem_system: wait for a request, check it is held, answer with Done at lat_n
    task automatic serve(input logic [15:0] ea, input logic [15:0] ed, input logic ewr,
                         input logic hit, input int lat_n, input logic [15:0] dout,
                         input int start_lat, output int wcnt);
        logic held_ok;
        exp_t e;
        wcnt = 0;
        while (!(Rd || Wr) && wcnt < 200) begin
            tick();
            wcnt++;
        end
        if (!(Rd || Wr)) begin
            check("issue_timeout", 32'(Rd | Wr), 32'd1);
            return;
        end
        held_ok = 1'b1;
        for (int l = start_lat; l < lat_n; l++) begin
            if (Addr !== ea || DataIn !== ed || Wr !== ewr || Rd !== !ewr) held_ok = 1'b0;
            tick();
        end
        if (Addr !== ea || DataIn !== ed || Wr !== ewr || Rd !== !ewr) held_ok = 1'b0;
        check("req_held", 32'(held_ok), 32'd1);
        Done     = 1'b1;
        CacheHit = hit;
        DataOut  = dout;
        tick();
        Done     = 1'b0;
        CacheHit = 1'b0;
        DataOut  = 16'h0000;
        check("rsp_valid", 32'(rsp_valid), 32'd1);
        check("req_cleared", 32'(Rd | Wr), 32'd0);
        if (sb.size() == 0) begin
            check("sb_entry", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check("rsp_data", 32'(rsp_data), 32'(e.data));
            check("rsp_hit",  32'(rsp_hit),  32'(e.hit));
            check("rsp_lat",  32'(rsp_lat),  32'(e.lat));
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_valid = 1'b0;
        in_wr    = 1'b0;
        in_rd    = 1'b0;
        in_addr  = 16'h0000;
        in_data  = 16'h0000;
        DataOut  = 16'h0000;
        Done     = 1'b0;
        Stall    = 1'b0;
        CacheHit = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_idle",     32'(idle), 32'd1);
        check("rst_rdwr",     32'({Rd, Wr}), 32'd0);
        check("rst_addr",     32'(Addr), 32'd0);
        check("rst_n_req",    32'(n_req), 32'd0);
        check("rst_rsp",      32'(rsp_valid), 32'd0);
        check("rst_errs",     32'({err_perf, err_drop, err_cmd}), 32'd0);
        check("rst_max_lat",  32'(max_lat), 32'd0);

        // Read hit at latency 2
        sb.push_back({16'h1234, 1'b1, 8'd2});
        push_cmd(1'b1, 1'b0, 16'h0010, 16'h0000);
        serve(16'h0010, 16'h0000, 1'b0, 1'b1, 2, 16'h1234, 1, waited);
        check("t1_n_reply", 32'(n_reply), 32'd1);
        check("t1_n_hit",   32'(n_hit), 32'd1);
        check("t1_n_req",   32'(n_req), 32'd1);
        check("t1_err_perf", 32'(err_perf), 32'd0);

        // Write miss at latency 12
        sb.push_back({16'h0000, 1'b0, 8'd12});
        push_cmd(1'b0, 1'b1, 16'h0020, 16'hBEEF);
        serve(16'h0020, 16'hBEEF, 1'b1, 1'b0, 12, 16'hDEAD, 1, waited);
        check("t2_n_reply", 32'(n_reply), 32'd2);
        check("t2_n_hit",   32'(n_hit), 32'd1);
        check("t2_err_perf", 32'(err_perf), 32'd0);

        // Slow hit, then over-budget miss
        sb.push_back({16'h5555, 1'b1, 8'd3});
        push_cmd(1'b1, 1'b0, 16'h0030, 16'h0000);
        serve(16'h0030, 16'h0000, 1'b0, 1'b1, 3, 16'h5555, 1, waited);
        check("t3_err_perf_hit", 32'(err_perf), 32'd1);
        sb.push_back({16'h6666, 1'b0, 8'd21});
        push_cmd(1'b1, 1'b0, 16'h0040, 16'h0000);
        serve(16'h0040, 16'h0000, 1'b0, 1'b0, 21, 16'h6666, 1, waited);
        check("t3_err_perf_sticky", 32'(err_perf), 32'd1);
        check("t3_n_hit", 32'(n_hit), 32'd2);
`ifdef MEM_REQ_MAXLAT_EN
        check("t3_max_lat",  32'(max_lat), 32'd21);
        check("t3_bad_addr", 32'(bad_addr), 32'h0030);
`else
        check("t3_max_lat_tied",  32'(max_lat), 32'd0);
        check("t3_bad_addr_tied", 32'(bad_addr), 32'd0);
`endif

        // Fill FIFO while stalled; fifth command is held off until space frees
        Stall    = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_rd   = (i % 2 == 0);
            in_wr   = (i % 2 != 0);
            in_addr = 16'h0100 + 16'(i);
            in_data = (i % 2 != 0) ? 16'hC000 + 16'(i) : 16'h0000;
            sb.push_back({((i % 2 == 0) ? 16'hA000 + 16'(i) : 16'h0000), 1'b1, 8'd2});
            check("t4_ready_pre", 32'(in_ready), 32'd1);
            tick();
        end
        in_rd   = 1'b1;
        in_wr   = 1'b0;
        in_addr = 16'h0104;
        in_data = 16'h0000;
        sb.push_back({16'hA004, 1'b1, 8'd2});
        check("t4_full", 32'(in_ready), 32'd0);
        tick();
        check("t4_full_held", 32'(in_ready), 32'd0);
        check("t4_stalled",   32'(Rd | Wr), 32'd0);
        check("t4_not_idle",  32'(idle), 32'd0);
        Stall = 1'b0;
        tick();
        check("t4_first_issue", 32'(Rd), 32'd1);
        check("t4_ready_freed", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        in_rd    = 1'b0;
        serve(16'h0100, 16'h0000, 1'b0, 1'b1, 2, 16'hA000, 2, waited);
        for (int i = 1; i < 5; i++) begin
            serve(16'h0100 + 16'(i),
                  ((i % 2 != 0) ? 16'hC000 + 16'(i) : 16'h0000),
                  (i % 2 != 0), 1'b1, 2,
                  ((i % 2 == 0) ? 16'hA000 + 16'(i) : 16'hFFFF), 1, waited);
            check("t4_dead_cycle", 32'(waited), 32'd1);
        end
        check("t4_n_req",   32'(n_req), 32'd9);
        check("t4_n_reply", 32'(n_reply), 32'd9);

        // Never answer: request is dropped at the timeout
        push_cmd(1'b1, 1'b0, 16'h0200, 16'h0000);
        waited = 0;
        while (!Rd && waited < 50) begin
            tick();
            waited++;
        end
        check("t5_issue", 32'(Rd), 32'd1);
        for (int l = 1; l < 64; l++) tick();
        check("t5_rd_at_64",  32'(Rd), 32'd1);
        check("t5_no_drop_yet", 32'(err_drop), 32'd0);
        tick();
        check("t5_err_drop", 32'(err_drop), 32'd1);
        check("t5_rd_clear", 32'(Rd), 32'd0);
        check("t5_no_rsp",   32'(rsp_valid), 32'd0);
        check("t5_n_reply",  32'(n_reply), 32'd9);
        sb.push_back({16'h7777, 1'b1, 8'd2});
        push_cmd(1'b1, 1'b0, 16'h0210, 16'h0000);
        serve(16'h0210, 16'h0000, 1'b0, 1'b1, 2, 16'h7777, 1, waited);
        check("t5_n_req",   32'(n_req), 32'd11);
        check("t5_n_reply", 32'(n_reply), 32'd10);

        // Reset while busy, then malformed commands
        push_cmd(1'b1, 1'b0, 16'h0300, 16'h0000);
        waited = 0;
        while (!Rd && waited < 50) begin
            tick();
            waited++;
        end
        for (int l = 1; l < 5; l++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_rdwr",    32'({Rd, Wr}), 32'd0);
        check("t6_idle",    32'(idle), 32'd1);
        check("t6_counters", 32'({n_req, n_reply, n_hit}), 32'd0);
        check("t6_errs",    32'({err_perf, err_drop, err_cmd}), 32'd0);
        check("t6_rsp",     32'(rsp_valid), 32'd0);
        Done = 1'b1;
        tick();
        Done = 1'b0;
        tick();
        check("t6_done_idle_rsp",   32'(rsp_valid), 32'd0);
        check("t6_done_idle_reply", 32'(n_reply), 32'd0);
        push_cmd(1'b0, 1'b0, 16'h0400, 16'h0000);
        check("t6_null_cmd_no_err", 32'(err_cmd), 32'd0);
        push_cmd(1'b1, 1'b1, 16'h0410, 16'h0000);
        check("t6_err_cmd", 32'(err_cmd), 32'd1);
        tick();
        tick();
        tick();
        check("t6_nothing_issued", 32'(Rd | Wr), 32'd0);
        check("t6_n_req_zero",     32'(n_req), 32'd0);
        check("t6_idle_end",       32'(idle), 32'd1);
        check("sb_drained",        32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
